// File: rtl/muxn_rr.sv
// muxn_rr: registered N-channel multiplexer with valid/ready handshakes.
// An arbiter (round-robin or fixed priority) grants one requesting channel
// per cycle. The granted word is loaded into a single output register,
// tagged with the index of the channel that supplied it.

module muxn_rr #(
  parameter int bitwidth  = 32,
  parameter int channels  = 4,
  parameter bit fixed_pri = 1'b0,
  localparam int selw     = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [channels*bitwidth-1:0] in_data,
  input  logic [channels-1:0]          in_valid,
  output logic [channels-1:0]          in_ready,
  output logic [bitwidth-1:0]          out_data,
  output logic [selw-1:0]              out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  // One extra bit so that base + offset can exceed channels-1 before wrapping.
  typedef logic [selw:0] wide_t;

  localparam wide_t       CH_W     = wide_t'(channels);
  localparam logic [selw-1:0] LAST_IDX = selw'(channels - 1);

  // Output register and round-robin pointer.
  logic                out_valid_q, out_valid_d;
  logic [bitwidth-1:0] out_data_q,  out_data_d;
  logic [selw-1:0]     out_sel_q,   out_sel_d;
  logic [selw-1:0]     rr_ptr_q,    rr_ptr_d;

  // Arbitration signals.
  logic                load_en;
  logic [selw-1:0]     search_base;
  wide_t               cand_w;
  logic                grant_found;
  logic [selw-1:0]     grant_idx;
  logic [channels-1:0] grant;

  // Per-channel view of the flat input bus.
  logic [bitwidth-1:0] ch_word [channels];

  for (genvar g = 0; g < channels; g++) begin : g_unpack
    assign ch_word[g] = in_data[g*bitwidth +: bitwidth];
  end

  // The register can take a word when empty or being drained this cycle.
  // Held off during reset so no channel sees an accept that is then discarded.
  assign load_en = !reset && (!out_valid_q || out_ready);

  // Fixed priority always starts the search at channel 0.
  assign search_base = fixed_pri ? '0 : rr_ptr_q;

  // Search channels starting at search_base, wrapping modulo channels.
  always_comb begin
    // NOTE: every variable written here gets a default first; otherwise a path
    // that skips the assignment would hold the old value and infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    for (int k = 0; k < channels; k++) begin
      cand_w = wide_t'(search_base) + wide_t'(k);
      if (cand_w >= CH_W) begin
        cand_w = cand_w - CH_W;
      end
      if (!grant_found && in_valid[cand_w[selw-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_w[selw-1:0];
      end
    end
  end

  // Decode the winning index into a one-hot grant vector.
  always_comb begin
    grant = '0;
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign in_ready = grant & {channels{load_en}};

  // Next state of the output register and pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (grant_found) begin
        out_valid_d = 1'b1;
        out_data_d  = ch_word[grant_idx];
        out_sel_d   = grant_idx;
        if (!fixed_pri) begin
          rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        // Drained with nothing to replace it; data and sel keep their last values.
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; a stalled register simply holds.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

  // At most one channel is accepted per cycle.
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(in_ready));

  // A stalled word stays put until the consumer takes it.
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_muxn_rr.sv
// Testbench for muxn_rr: one round-robin and one fixed-priority instance share
// the same stimulus; a cycle-level reference model predicts both, and directed
// sequences pin key results with literal values.

module tb_muxn_rr;

  localparam int BW = 32;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH*BW-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic          out_ready;
  logic [BW-1:0] ch_data [CH];

  logic [CH-1:0] rr_ready, fp_ready;
  logic [BW-1:0] rr_data,  fp_data;
  logic [1:0]    rr_sel,   fp_sel;
  logic          rr_valid, fp_valid;

  int n_vec  = 0;
  int n_miss = 0;
  bit armed  = 1'b0;

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  bit          m_valid [2];
  logic [31:0] m_data  [2];
  int          m_sel   [2];
  int          m_ptr   [2];

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign in_data[g*BW +: BW] = ch_data[g];
  end

  muxn_rr #(.bitwidth(BW), .channels(CH), .fixed_pri(1'b0)) dut_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_ready), .out_data(rr_data), .out_sel(rr_sel),
    .out_valid(rr_valid), .out_ready(out_ready));

  muxn_rr #(.bitwidth(BW), .channels(CH), .fixed_pri(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_ready), .out_data(fp_data), .out_sel(fp_sel),
    .out_valid(fp_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting channel in search order; -1 when nobody requests.
  function automatic int pick(input logic [CH-1:0] v, input int ptr, input bit fp);
    int vi;
    int c;
    vi = int'(v);
    for (int k = 0; k < CH; k++) begin
      c = fp ? k : (ptr + k) % CH;
      if (((vi >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic logic [CH-1:0] exp_ready(input int d);
    int g;
    if (reset) return '0;
    if (m_valid[d] && !out_ready) return '0;
    g = pick(in_valid, m_ptr[d], d == 1);
    if (g < 0) return '0;
    return 4'b0001 << g;
  endfunction

  // Model update on each active edge.
  always @(posedge clk) begin
    int g;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_valid[d] = 1'b0;
        m_data[d]  = '0;
        m_sel[d]   = 0;
        m_ptr[d]   = 0;
      end else if (!m_valid[d] || out_ready) begin
        g = pick(in_valid, m_ptr[d], d == 1);
        if (g >= 0) begin
          m_valid[d] = 1'b1;
          m_data[d]  = ch_data[g];
          m_sel[d]   = g;
          m_ptr[d]   = (g + 1) % CH;
        end else begin
          m_valid[d] = 1'b0;
        end
      end
    end
    armed = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      check("rr.out_valid", 32'(rr_valid), 32'(m_valid[0]));
      check("rr.out_data",  rr_data,       m_data[0]);
      check("rr.out_sel",   32'(rr_sel),   m_sel[0]);
      check("rr.in_ready",  32'(rr_ready), 32'(exp_ready(0)));
      check("fp.out_valid", 32'(fp_valid), 32'(m_valid[1]));
      check("fp.out_data",  fp_data,       m_data[1]);
      check("fp.out_sel",   32'(fp_sel),   m_sel[1]);
      check("fp.in_ready",  32'(fp_ready), 32'(exp_ready(1)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [CH-1:0] tbl_valid [12] = '{4'b1111, 4'b0000, 4'b0101, 4'b1000,
                                    4'b0011, 4'b1110, 4'b0001, 4'b1111,
                                    4'b0110, 4'b1001, 4'b0100, 4'b1011};
  bit            tbl_ready [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    out_ready = 1'b1;
    in_valid  = '1;
    for (int i = 0; i < CH; i++) ch_data[i] = 32'hA0 + 32'(i);
    reset = 1'b1;

    // Reset held two cycles with every channel requesting.
    repeat (2) cyc();
    check("t1.valid_in_reset", 32'(rr_valid), 32'h0);
    check("t1.ready_in_reset", 32'(rr_ready), 32'h0);
    check("t1.data_in_reset",  rr_data,       32'h0);
    reset = 1'b0;

    // All valid, consumer always ready: 0,1,2,3,0 one per cycle.
    for (int n = 0; n < 5; n++) begin
      cyc();
      check("t2.valid",  32'(rr_valid), 32'h1);
      check("t2.sel",    32'(rr_sel),   32'(n % 4));
      check("t2.data",   rr_data,       32'hA0 + 32'(n % 4));
      check("t2.fp_sel", 32'(fp_sel),   32'h0);
    end

    // Drain to empty.
    in_valid = '0;
    cyc();
    check("t3.empty", 32'(rr_valid), 32'h0);

    // Only ch2 valid, consumer stalled: accepted once and held stable.
    ch_data[2] = 32'hDEAD;
    in_valid   = 4'b0100;
    out_ready  = 1'b0;
    cyc();
    ch_data[2] = 32'hBEEF;
    for (int s = 0; s < 3; s++) begin
      check("t3.stall_valid", 32'(rr_valid), 32'h1);
      check("t3.stall_data",  rr_data,       32'hDEAD);
      check("t3.stall_ready", 32'(rr_ready), 32'h0);
      if (s < 2) cyc();
    end
    out_ready = 1'b1;
    #1;
    check("t3.release_ready", 32'(rr_ready), 32'h4);
    cyc();
    check("t3.next_data", rr_data,       32'hBEEF);
    check("t3.next_sel",  32'(rr_sel),   32'h2);

    // Pointer at 3: ch1 and ch3 valid -> ch3 then ch1.
    in_valid   = 4'b1010;
    ch_data[1] = 32'h11;
    ch_data[3] = 32'h33;
    cyc();
    check("t4.sel_a",    32'(rr_sel), 32'h3);
    check("t4.data_a",   rr_data,     32'h33);
    check("t4.fp_sel_a", 32'(fp_sel), 32'h1);
    cyc();
    check("t4.sel_b",    32'(rr_sel), 32'h1);
    check("t4.data_b",   rr_data,     32'h11);
    check("t4.fp_sel_b", 32'(fp_sel), 32'h1);

    // ch0 and ch3 continuously valid: fixed priority always serves ch0.
    in_valid   = 4'b1001;
    ch_data[0] = 32'h100;
    ch_data[3] = 32'h300;
    for (int n = 0; n < 4; n++) begin
      cyc();
      check("t5.fp_sel",   32'(fp_sel),   32'h0);
      check("t5.fp_data",  fp_data,       32'h100);
      check("t5.fp_ready", 32'(fp_ready), 32'h1);
      check("t5.rr_sel",   32'(rr_sel),   (n % 2 == 0) ? 32'h3 : 32'h0);
    end

    // Load ch1 so the pointer moves to 2, then reset mid-stream.
    in_valid   = 4'b0010;
    ch_data[1] = 32'h1111;
    cyc();
    check("t6.pre_sel", 32'(rr_sel), 32'h1);
    reset      = 1'b1;
    out_ready  = 1'b0;
    in_valid   = 4'b0110;
    ch_data[2] = 32'h2222;
    #1;
    check("t6.ready_in_reset", 32'(rr_ready), 32'h0);
    cyc();
    check("t6.valid_dropped", 32'(rr_valid), 32'h0);
    check("t6.data_cleared",  rr_data,       32'h0);
    check("t6.fp_valid",      32'(fp_valid), 32'h0);
    reset     = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("t6.first_sel",  32'(rr_sel), 32'h1);
    check("t6.first_data", rr_data,     32'h1111);
    cyc();
    check("t6.second_sel", 32'(rr_sel), 32'h2);
    check("t6.second_data", rr_data,    32'h2222);

    // Mixed request/stall patterns, checked by the model every cycle.
    for (int k = 0; k < 12; k++) begin
      in_valid  = tbl_valid[k];
      out_ready = tbl_ready[k];
      for (int i = 0; i < CH; i++) ch_data[i] = 32'(32'h5000 + k * 16 + i);
      cyc();
    end
    out_ready = 1'b1;
    in_valid  = '0;
    repeat (2) cyc();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
